// File: rtl/decod_pkg.sv
// Shared types and constants for the 4-to-16 decoder strobe path.
// Line names follow the decoder output declaration order: bit0 = f ... bit15 = u.
package decod_pkg;

    localparam int NUM_LINES = 16;
    localparam int IDX_W     = 4;

    typedef logic [NUM_LINES-1:0] sel_t;
    typedef logic [IDX_W-1:0]     idx_t;

    localparam idx_t LINE_F = 4'd0;
    localparam idx_t LINE_G = 4'd1;
    localparam idx_t LINE_H = 4'd2;
    localparam idx_t LINE_I = 4'd3;
    localparam idx_t LINE_J = 4'd4;
    localparam idx_t LINE_K = 4'd5;
    localparam idx_t LINE_L = 4'd6;
    localparam idx_t LINE_M = 4'd7;
    localparam idx_t LINE_N = 4'd8;
    localparam idx_t LINE_O = 4'd9;
    localparam idx_t LINE_P = 4'd10;
    localparam idx_t LINE_Q = 4'd11;
    localparam idx_t LINE_R = 4'd12;
    localparam idx_t LINE_S = 4'd13;
    localparam idx_t LINE_T = 4'd14;
    localparam idx_t LINE_U = 4'd15;

endpackage

// File: rtl/onehot_enc16.sv
// Combinational legality check and encoder for 16 one-hot strobe lines.
// Ports:
//   sel       - strobe lines
//   idx       - position of the set bit (meaningful only when is_onehot)
//   is_zero   - no line set
//   is_onehot - exactly one line set
//   is_multi  - two or more lines set
module onehot_enc16
    import decod_pkg::*;
(
    input  sel_t       sel,
    output idx_t       idx,
    output logic       is_zero,
    output logic       is_onehot,
    output logic       is_multi
);

    logic seen;
    logic multi;

    // Track "any bit seen" and "a second bit seen" instead of a full popcount.
    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (sel[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                idx  = idx_t'(i);
            end
        end
    end

    assign is_zero   = !seen;
    assign is_multi  = multi;
    assign is_onehot = seen && !multi;

endmodule

// File: rtl/decod_strobe_fifo.sv
// Checks decoder strobes for one-hot legality, encodes legal strobes into an
// index and queues them in a small FIFO drained by a valid/ready consumer.
// Multi-hot patterns and overflow drops raise sticky flags and are counted.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   sel_i                - decoder strobes (bit0 = f ... bit15 = u)
//   clear_i              - clears sticky flags and counters
//   out_valid/out_ready  - head handshake
//   out_idx              - head event index
//   level                - occupancy 0..DEPTH
//   err_multi, err_ovf   - sticky error flags
//   multi_cnt, drop_cnt  - saturating error counters
module decod_strobe_fifo
    import decod_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  sel_t                     sel_i,
    input  logic                     clear_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output idx_t                     out_idx,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_multi,
    output logic                     err_ovf,
    output logic [CNT_W-1:0]         multi_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    idx_t          enc_idx;
    logic          is_zero;
    logic          is_onehot;
    logic          is_multi;

    idx_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    onehot_enc16 u_enc (
        .sel       (sel_i),
        .idx       (enc_idx),
        .is_zero   (is_zero),
        .is_onehot (is_onehot),
        .is_multi  (is_multi)
    );

    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = is_onehot && (!full || pop);
    assign drop      = is_onehot && full && !pop;

    // Gate the head with out_valid so an empty FIFO presents index 0.
    assign out_idx   = out_valid ? mem[rd_ptr] : '0;

    // Storage carries no reset; validity comes from level alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Clear takes precedence over an error arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_multi <= 1'b0;
            err_ovf   <= 1'b0;
            multi_cnt <= '0;
            drop_cnt  <= '0;
        end else if (clear_i) begin
            err_multi <= 1'b0;
            err_ovf   <= 1'b0;
            multi_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (is_multi) begin
                err_multi <= 1'b1;
                multi_cnt <= sat_inc(multi_cnt);
            end
            if (drop) begin
                err_ovf  <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_decod_strobe_fifo.sv
module tb_decod_strobe_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sel_i;
    logic        clear_i;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic [2:0]  level;
    logic        err_multi;
    logic        err_ovf;
    logic [7:0]  multi_cnt;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    decod_strobe_fifo #(.DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_i     (sel_i),
        .clear_i   (clear_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .level     (level),
        .err_multi (err_multi),
        .err_ovf   (err_ovf),
        .multi_cnt (multi_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply current inputs across one rising edge, then settle before checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sel_i     = '0;
        clear_i   = 1'b0;
        out_ready = 1'b0;

        // Reset then idle
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_emulti", err_multi, 0);
        chk("rst_eovf", err_ovf, 0);
        chk("rst_mcnt", multi_cnt, 0);
        chk("rst_dcnt", drop_cnt, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("idle_empty_ready_level", level, 0);

        // Single event, one-cycle latency, popped next edge
        sel_i = 16'h0008;
        tick();
        sel_i = '0;
        chk("single_valid", out_valid, 1);
        chk("single_idx", out_idx, 3);
        chk("single_level", level, 1);
        tick();
        chk("single_popped_level", level, 0);
        chk("single_popped_valid", out_valid, 0);

        // Multi-hot for 3 cycles
        sel_i = 16'h0101;
        repeat (3) tick();
        sel_i = '0;
        chk("multi_level", level, 0);
        chk("multi_flag", err_multi, 1);
        chk("multi_cnt", multi_cnt, 3);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("multi_clr_flag", err_multi, 0);
        chk("multi_clr_cnt", multi_cnt, 0);

        // Clear wins over a simultaneous error
        sel_i = 16'h0101;
        clear_i = 1'b1;
        tick();
        sel_i = '0;
        clear_i = 1'b0;
        chk("clrwin_flag", err_multi, 0);
        chk("clrwin_cnt", multi_cnt, 0);

        // Overflow: push 0..5 with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sel_i = 16'(1) << i;
            tick();
        end
        sel_i = '0;
        chk("ovf_level", level, 4);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_dcnt", drop_cnt, 2);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("ovf_drain_valid", out_valid, 1);
            chk("ovf_drain_idx", out_idx, k);
            tick();
        end
        chk("ovf_drained_level", level, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("ovf_clr_flag", err_ovf, 0);
        chk("ovf_clr_cnt", drop_cnt, 0);

        // Full with simultaneous pop: push-through accepted
        out_ready = 1'b0;
        for (int i = 10; i < 14; i++) begin
            sel_i = 16'(1) << i;
            tick();
        end
        chk("full_level", level, 4);
        chk("full_head", out_idx, 10);
        out_ready = 1'b1;
        sel_i = 16'h8000;
        tick();
        sel_i = '0;
        chk("pt_level", level, 4);
        chk("pt_dcnt", drop_cnt, 0);
        chk("pt_eovf", err_ovf, 0);
        chk("pt_idx0", out_idx, 11);
        tick();
        chk("pt_idx1", out_idx, 12);
        tick();
        chk("pt_idx2", out_idx, 13);
        tick();
        chk("pt_idx3", out_idx, 15);
        tick();
        chk("pt_drained_level", level, 0);

        // Counter saturation
        sel_i = 16'hFFFF;
        repeat (260) tick();
        sel_i = '0;
        chk("sat_cnt", multi_cnt, 255);
        chk("sat_flag", err_multi, 1);

        // Reset mid-operation discards entries and the concurrent event
        out_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            sel_i = 16'(1) << i;
            tick();
        end
        chk("mid_level_pre", level, 3);
        rst_n = 1'b0;
        sel_i = 16'h0002;
        tick();
        chk("mid_level", level, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_mcnt", multi_cnt, 0);
        chk("mid_emulti", err_multi, 0);
        rst_n = 1'b1;
        sel_i = '0;
        tick();
        chk("mid_after_level", level, 0);
        chk("mid_after_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
